// File: rtl/sys_ibus_master.sv
// sys_ibus_master
//   Initiator side of the systolic I/O-buffer ibus. Runs one matrix job per
//   accepted command: streams A0,A1,B0,B1 words from din into the input
//   buffers, writes MAX_CNTR and RUN_CNTR, writes START, polls run_status
//   until the array is idle, then reads S0_0,S1_0,S0_1,S1_1 back out on dout.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      job command handshake (ready only while idle)
//   cmd_len                  words per A/B lane, 0 skips the load phase
//   cmd_max, cmd_run         values written to MAX_CNTR / RUN_CNTR
//   cmd_olen                 words read per S buffer, 0 skips readout
//   din_valid/ready/data     input word stream, lane-major A0,A1,B0,B1
//   dout_valid/ready/data    result word stream, dout_last on final S1_1 word
//   dout_last
//   ren, radr, rdata         ibus read channel (rdata valid RD_LAT after ren)
//   wen, wadr, wdata         ibus write channel, one access per wen cycle
//   busy                     job in progress
//   done                     one-cycle pulse on successful completion
//   err                      sticky poll timeout, cleared by next command
//
// State table
//   state    | meaning
//   IDLE     | waiting for a command, cmd_ready high
//   LOAD     | accepting din words, one buffer write per handshake
//   CFG_MAX  | issue MAX_CNTR write
//   CFG_RUN  | issue RUN_CNTR write
//   START    | issue START write
//   POLL     | one status read of 0xFFF0, decide on run_status
//   WAIT     | POLL_GAP idle cycles between polls
//   RD       | one S-buffer read
//   OUT      | present the read word on dout until accepted
//   DONE     | done pulse, back to IDLE
//   ERR      | poll timeout, err set, back to IDLE

module sys_ibus_master #(
   parameter int unsigned RD_LAT   = 2,
   parameter int unsigned POLL_GAP = 4,
   parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_len,
   input  logic [7:0]  cmd_max,
   input  logic [7:0]  cmd_run,
   input  logic [8:0]  cmd_olen,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic [15:0] din_data,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [15:0] dout_data,
   output logic        dout_last,
   output logic        ren,
   output logic [15:0] radr,
   input  logic [15:0] rdata,
   output logic        wen,
   output logic [15:0] wadr,
   output logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [7:0]  LAT_LAST = 8'(RD_LAT);
   // WAIT counts down to zero inclusive, so it lasts exactly POLL_GAP cycles.
   localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

   localparam logic [15:0] ADR_START = 16'hFFF0;
   localparam logic [15:0] ADR_MAX   = 16'hFFF1;
   localparam logic [15:0] ADR_RUN   = 16'hFFF2;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_CFG_MAX, S_CFG_RUN, S_START,
      S_POLL, S_WAIT, S_RD, S_OUT, S_DONE, S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  len_q, len_d;
   logic [7:0]  max_q, max_d;
   logic [7:0]  run_q, run_d;
   logic [8:0]  olen_q, olen_d;
   logic [9:0]  idx_q, idx_d;
   logic [1:0]  lane_q, lane_d;
   logic [8:0]  j_q, j_d;
   logic [1:0]  sbuf_q, sbuf_d;
   logic [15:0] poll_cnt_q, poll_cnt_d;
   logic [15:0] gap_cnt_q, gap_cnt_d;
   logic [7:0]  lat_cnt_q, lat_cnt_d;
   logic        ren_q, ren_d;
   logic [15:0] radr_q, radr_d;
   logic        wen_q, wen_d;
   logic [15:0] wadr_q, wadr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        dout_valid_q, dout_valid_d;
   logic [15:0] dout_data_q, dout_data_d;
   logic        dout_last_q, dout_last_d;
   logic        err_q, err_d;

   assign cmd_ready  = (state_q == S_IDLE);
   assign din_ready  = (state_q == S_LOAD);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign ren        = ren_q;
   assign radr       = radr_q;
   assign wen        = wen_q;
   assign wadr       = wadr_q;
   assign wdata      = wdata_q;
   assign dout_valid = dout_valid_q;
   assign dout_data  = dout_data_q;
   assign dout_last  = dout_last_q;
   assign err        = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         max_q        <= '0;
         run_q        <= '0;
         olen_q       <= '0;
         idx_q        <= '0;
         lane_q       <= '0;
         j_q          <= '0;
         sbuf_q       <= '0;
         poll_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         lat_cnt_q    <= '0;
         ren_q        <= 1'b0;
         radr_q       <= '0;
         wen_q        <= 1'b0;
         wadr_q       <= '0;
         wdata_q      <= '0;
         dout_valid_q <= 1'b0;
         dout_data_q  <= '0;
         dout_last_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         max_q        <= max_d;
         run_q        <= run_d;
         olen_q       <= olen_d;
         idx_q        <= idx_d;
         lane_q       <= lane_d;
         j_q          <= j_d;
         sbuf_q       <= sbuf_d;
         poll_cnt_q   <= poll_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         ren_q        <= ren_d;
         radr_q       <= radr_d;
         wen_q        <= wen_d;
         wadr_q       <= wadr_d;
         wdata_q      <= wdata_d;
         dout_valid_q <= dout_valid_d;
         dout_data_q  <= dout_data_d;
         dout_last_q  <= dout_last_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      max_d        = max_q;
      run_d        = run_q;
      olen_d       = olen_q;
      idx_d        = idx_q;
      lane_d       = lane_q;
      j_d          = j_q;
      sbuf_d       = sbuf_q;
      poll_cnt_d   = poll_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      ren_d        = ren_q;
      radr_d       = radr_q;
      wen_d        = 1'b0;
      wadr_d       = wadr_q;
      wdata_d      = wdata_q;
      dout_valid_d = dout_valid_q;
      dout_data_d  = dout_data_q;
      dout_last_d  = dout_last_q;
      err_d        = err_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               len_d      = cmd_len;
               max_d      = cmd_max;
               run_d      = cmd_run;
               olen_d     = cmd_olen;
               err_d      = 1'b0;
               idx_d      = '0;
               lane_d     = '0;
               j_d        = '0;
               sbuf_d     = '0;
               poll_cnt_d = '0;
               state_d    = (cmd_len == 10'd0) ? S_CFG_MAX : S_LOAD;
            end
         end

         S_LOAD: begin
            if (din_valid) begin
               // Lane bases are 0x400 apart and idx stays below cmd_len,
               // so the address is a plain concatenation.
               wen_d   = 1'b1;
               wadr_d  = {4'b0000, lane_q, idx_q};
               wdata_d = din_data;
               if (idx_q == len_q - 10'd1) begin
                  idx_d  = '0;
                  lane_d = lane_q + 2'd1;
                  if (lane_q == 2'd3) begin
                     state_d = S_CFG_MAX;
                  end
               end else begin
                  idx_d = idx_q + 10'd1;
               end
            end
         end

         S_CFG_MAX: begin
            wen_d   = 1'b1;
            wadr_d  = ADR_MAX;
            wdata_d = {8'h00, max_q};
            state_d = S_CFG_RUN;
         end

         S_CFG_RUN: begin
            wen_d   = 1'b1;
            wadr_d  = ADR_RUN;
            wdata_d = {8'h00, run_q};
            state_d = S_START;
         end

         S_START: begin
            wen_d   = 1'b1;
            wadr_d  = ADR_START;
            wdata_d = 16'h0001;
            state_d = S_POLL;
         end

         S_POLL: begin
            // Entered from START with ren low (START write still on the bus);
            // entered from WAIT with the read already launched.
            if (!ren_q) begin
               ren_d     = 1'b1;
               radr_d    = ADR_START;
               lat_cnt_d = LAT_LAST;
            end else if (lat_cnt_q != 8'd0) begin
               lat_cnt_d = lat_cnt_q - 8'd1;
            end else begin
               ren_d = 1'b0;
               if (!rdata[0]) begin
                  state_d = (olen_q == 9'd0) ? S_DONE : S_RD;
               end else begin
                  poll_cnt_d = poll_cnt_q + 16'd1;
                  if (poll_cnt_q + 16'd1 == POLL_MAX) begin
                     err_d   = 1'b1;
                     state_d = S_ERR;
                  end else begin
                     gap_cnt_d = GAP_LOAD;
                     state_d   = S_WAIT;
                  end
               end
            end
         end

         S_WAIT: begin
            if (gap_cnt_q == 16'd0) begin
               ren_d     = 1'b1;
               radr_d    = ADR_START;
               lat_cnt_d = LAT_LAST;
               state_d   = S_POLL;
            end else begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end
         end

         S_RD: begin
            if (!ren_q) begin
               ren_d     = 1'b1;
               radr_d    = {1'b1, 4'b0000, sbuf_q, j_q};
               lat_cnt_d = LAT_LAST;
            end else if (lat_cnt_q != 8'd0) begin
               lat_cnt_d = lat_cnt_q - 8'd1;
            end else begin
               ren_d        = 1'b0;
               dout_valid_d = 1'b1;
               dout_data_d  = rdata;
               dout_last_d  = (sbuf_q == 2'd3) && (j_q == olen_q - 9'd1);
               state_d      = S_OUT;
            end
         end

         S_OUT: begin
            if (dout_ready) begin
               dout_valid_d = 1'b0;
               dout_last_d  = 1'b0;
               if (dout_last_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RD;
                  if (j_q == olen_q - 9'd1) begin
                     j_d    = '0;
                     sbuf_d = sbuf_q + 2'd1;
                  end else begin
                     j_d = j_q + 9'd1;
                  end
               end
            end
         end

         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

endmodule
